align_router: RTL and testbench
===============================

ALIGN_ROUTER -- requirements
Module: align_router

Interface
REQ-001 SHALL have parameter SQRT_N, default 32: mesh side length; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: destination-address width, equal to log2(SQRT_N*SQRT_N).
REQ-003 SHALL have parameters ROW and COL, default 0: this PE's mesh position; PE index = ROW*SQRT_N+COL.
REQ-004 SHALL have ports clk (in, 1) and rst (in, 1); one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start (in, 1): begins an alignment pass.
REQ-006 SHALL have port i_pkt (in, 2*ADDR_WIDTH): sorted packet from the PE; {dest_addr[2*AW-1:AW], payload[AW-1:0]}.
REQ-007 SHALL have port i_valid (in, 1): i_pkt holds a real packet.
REQ-008 SHALL have port i_shift_u (in, 2*ADDR_WIDTH+1): o_shift of the PE above, ring-wrapped; MSB is valid.
REQ-009 SHALL have port i_shift_l (in, 2*ADDR_WIDTH+1): o_shift of the PE to the left, ring-wrapped.
REQ-010 SHALL have port o_shift (out, 2*ADDR_WIDTH+1): {valid, packet} of the shift register.
REQ-011 SHALL have port o_pkt (out, 2*ADDR_WIDTH), plus o_valid (out, 1), for the delivered packet.
REQ-012 SHALL have port o_done (out, 1): one-cycle completion pulse.
REQ-013 SHALL have port o_conflict (out, 1): sticky drop flag.
REQ-014 SHALL have port o_conflict_cnt (out, 8): dropped-packet count.

Function
REQ-015 SHALL have four states: IDLE, ROW_SHIFT, COL_SHIFT, DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in either shift state is ignored.
REQ-017 On accepted start: shift <= {i_valid, i_pkt}; hold cleared; o_valid cleared; counter <= 0; o_conflict and o_conflict_cnt cleared; state goes to ROW_SHIFT.
REQ-018 Each ROW_SHIFT edge: if shift is valid, dest_row = dest_addr / SQRT_N equals ROW, and hold is empty, then capture into hold; then shift <= i_shift_u; counter increments.
REQ-019 SHALL treat a row match while hold is already full as a conflict: packet dropped, o_conflict set, count incremented.
REQ-020 On the ROW_SHIFT edge with counter == SQRT_N-1: shift <= hold, including a capture made that same edge; hold cleared; counter <= 0; state goes to COL_SHIFT.
REQ-021 COL_SHIFT SHALL mirror REQ-018..019 using dest_col = dest_addr % SQRT_N == COL and i_shift_l.
REQ-022 On the COL_SHIFT edge with counter == SQRT_N-1: o_pkt/o_valid <= final hold; state goes to DONE; o_done high for exactly the next cycle.
REQ-023 Latency SHALL be: o_done high 2*SQRT_N+1 edges after the start edge; o_pkt/o_valid held until the next accepted start.
REQ-024 Invalid shift entries SHALL never match or count as conflicts.
REQ-025 o_shift SHALL be registered only; no combinational path from any input.

Reset
REQ-026 rst SHALL force IDLE, with shift, hold, o_pkt, o_valid, o_done, o_conflict, o_conflict_cnt and counter all 0, from any state including mid-pass.
REQ-027 rst SHALL take priority over a simultaneous start.

Configuration
REQ-028 Macro ALIGN_ROUTER_CONFLICT_CNT_EN defined: o_conflict_cnt counts drops per pass and saturates at 255.
REQ-029 Macro ALIGN_ROUTER_CONFLICT_CNT_EN undefined: no counter logic; o_conflict_cnt tied to 0; o_conflict unaffected.

Structure
REQ-030 Shared package align_pkg SHALL hold: state encoding; packet field offsets; functions dest_row()/dest_col().
REQ-031 The pass-length counter SHALL be one sub-module instance, align_cycle_counter (width log2(SQRT_N)+1, sync clear).

Verification
REQ-032 4x4 mesh, each PE i holds dest=15-i, payload=i -> after o_done, PE j has o_pkt payload 15-j, o_valid=1, o_conflict=0.
REQ-033 Single PE; start with i_valid=1, dest=own index, all shift inputs invalid -> o_done exactly 9 edges after start (SQRT_N=4), o_pkt == i_pkt.
REQ-034 Two packets target PE 5 in a 4x4 mesh -> PE 5 keeps the first-arriving packet, o_conflict=1, o_conflict_cnt=1 with macro and 0 without.
REQ-035 start pulsed during ROW_SHIFT -> ignored, completion timing unchanged; start in DONE -> new pass begins and o_valid clears.
REQ-036 rst asserted at COL_SHIFT counter 2 -> next cycle IDLE, all outputs 0; o_done never pulses.
REQ-037 All i_valid=0 -> o_done pulses, o_valid=0 everywhere, no conflicts.

Source files
------------

// File: rtl/align_router_pkg.sv
// Shared definitions for the mesh alignment router: state encoding, packet
// field layout and destination-address decoding helpers.
package align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ROW_SHIFT = 2'd1,
        ST_COL_SHIFT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Packet = {dest_addr, payload}; the shift/hold registers add a valid MSB.
    localparam int PKT_PAYLOAD_LSB = 0;

    function automatic int pkt_dest_lsb(input int addr_width);
        return addr_width;
    endfunction

    function automatic int shift_valid_bit(input int addr_width);
        return 2 * addr_width;
    endfunction

    function automatic int dest_row(input int dest, input int sqrt_n);
        return dest / sqrt_n;
    endfunction

    function automatic int dest_col(input int dest, input int sqrt_n);
        return dest % sqrt_n;
    endfunction

endpackage

// File: rtl/align_router_cycle_counter.sv
// Pass-length counter: counts shift edges within a row or column phase,
// with a synchronous clear that wins over the enable.
module align_cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/align_router.sv
// One PE of the two-phase (column then row ring) packet alignment mesh.
// Optional macro ALIGN_ROUTER_CONFLICT_CNT_EN enables the saturating drop counter.
module align_router
    import align_pkg::*;
#(
    parameter int SQRT_N     = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ROW        = 0,
    parameter int COL        = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*ADDR_WIDTH-1:0] i_pkt,
    input  logic                    i_valid,
    input  logic [2*ADDR_WIDTH:0]   i_shift_u,
    input  logic [2*ADDR_WIDTH:0]   i_shift_l,
    output logic [2*ADDR_WIDTH:0]   o_shift,
    output logic [2*ADDR_WIDTH-1:0] o_pkt,
    output logic                    o_valid,
    output logic                    o_done,
    output logic                    o_conflict,
    output logic [7:0]              o_conflict_cnt
);

    localparam int CW       = $clog2(SQRT_N) + 1;
    localparam int PW       = 2 * ADDR_WIDTH;
    localparam int VBIT     = shift_valid_bit(ADDR_WIDTH);
    localparam int DEST_LSB = pkt_dest_lsb(ADDR_WIDTH);

    state_t          r_state;
    logic [PW:0]     r_shift;
    logic [PW:0]     r_hold;
    logic [PW-1:0]   r_pkt;
    logic            r_valid;
    logic            r_done;
    logic            r_done_arm;
    logic            r_conflict;

    logic [CW-1:0]         w_count;
    logic [ADDR_WIDTH-1:0] w_dest;
    logic                  w_accept;
    logic                  w_shifting;
    logic                  w_last;
    logic                  w_match;
    logic                  w_capture;
    logic                  w_conflict;
    logic [PW:0]           w_hold_next;

    assign w_accept   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_shifting = (r_state == ST_ROW_SHIFT) || (r_state == ST_COL_SHIFT);
    assign w_last     = w_shifting && (w_count == CW'(SQRT_N - 1));
    assign w_dest     = r_shift[DEST_LSB +: ADDR_WIDTH];

    // Invalid entries never match, so they can neither be captured nor dropped.
    assign w_match = r_shift[VBIT] &&
        (((r_state == ST_ROW_SHIFT) && (dest_row(int'(w_dest), SQRT_N) == ROW)) ||
         ((r_state == ST_COL_SHIFT) && (dest_col(int'(w_dest), SQRT_N) == COL)));
    assign w_capture   = w_match && !r_hold[VBIT];
    assign w_conflict  = w_match && r_hold[VBIT];
    assign w_hold_next = w_capture ? r_shift : r_hold;

    align_cycle_counter #(.WIDTH(CW)) u_cycle_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept || w_last),
        .i_en    (w_shifting),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_pkt      <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_done_arm <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            // The done pulse trails entry into DONE by one edge.
            r_done     <= r_done_arm;
            r_done_arm <= 1'b0;
            if (w_conflict) begin
                r_conflict <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_shift    <= {i_valid, i_pkt};
                        r_hold     <= '0;
                        r_valid    <= 1'b0;
                        r_conflict <= 1'b0;
                        r_state    <= ST_ROW_SHIFT;
                    end
                end
                ST_ROW_SHIFT: begin
                    if (w_last) begin
                        r_shift <= w_hold_next;
                        r_hold  <= '0;
                        r_state <= ST_COL_SHIFT;
                    end else begin
                        r_shift <= i_shift_u;
                        r_hold  <= w_hold_next;
                    end
                end
                ST_COL_SHIFT: begin
                    r_shift <= i_shift_l;
                    if (w_last) begin
                        r_pkt      <= w_hold_next[PW-1:0];
                        r_valid    <= w_hold_next[VBIT];
                        r_hold     <= '0;
                        r_done_arm <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_hold <= w_hold_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALIGN_ROUTER_CONFLICT_CNT_EN
    logic [7:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && r_conflict_cnt != 8'hFF) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_conflict_cnt = 8'd0;
`endif

    assign o_shift    = r_shift;
    assign o_pkt      = r_pkt;
    assign o_valid    = r_valid;
    assign o_done     = r_done;
    assign o_conflict = r_conflict;

endmodule

// File: tb/tb_align_router.sv
// Scoreboard bench for align_router: a standalone PE plus a 4x4 ring mesh.
// Drivers push expected results; monitors pop and compare on each o_done.
module tb_align_router;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int PW = 2 * AW;
    localparam int SW = PW + 1;
    localparam int NP = N * N;

`ifdef ALIGN_ROUTER_CONFLICT_CNT_EN
    localparam logic [7:0] CNT1 = 8'd1;
`else
    localparam logic [7:0] CNT1 = 8'd0;
`endif

    typedef struct {
        logic [PW-1:0] pkt;
        logic          valid;
        logic          conflict;
        logic [7:0]    cnt;
        int            done_edge;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sq[$];
    exp_t mq[$];
    exp_t s_e;
    exp_t m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standalone PE at (1,2), index 6, with idle ring neighbours.
    logic          s_rst, s_start, s_ivalid;
    logic [PW-1:0] s_ipkt, s_pkt;
    logic [SW-1:0] s_shift_u, s_shift_l, s_shift;
    logic          s_valid, s_done, s_conflict;
    logic [7:0]    s_cnt;

    align_router #(.SQRT_N(N), .ADDR_WIDTH(AW), .ROW(1), .COL(2)) u_single (
        .clk(clk), .rst(s_rst), .start(s_start), .i_pkt(s_ipkt), .i_valid(s_ivalid),
        .i_shift_u(s_shift_u), .i_shift_l(s_shift_l), .o_shift(s_shift),
        .o_pkt(s_pkt), .o_valid(s_valid), .o_done(s_done),
        .o_conflict(s_conflict), .o_conflict_cnt(s_cnt)
    );

    // 4x4 mesh with ring wrap in both dimensions.
    logic          m_rst, m_start;
    logic [PW-1:0] m_ipkt  [NP];
    logic          m_ivalid[NP];
    logic [SW-1:0] m_shift [NP];
    logic [PW-1:0] m_pkt   [NP];
    logic          m_valid [NP];
    logic          m_done  [NP];
    logic          m_conf  [NP];
    logic [7:0]    m_cnt   [NP];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            align_router #(.SQRT_N(N), .ADDR_WIDTH(AW), .ROW(r), .COL(c)) u_pe (
                .clk(clk), .rst(m_rst), .start(m_start),
                .i_pkt(m_ipkt[r*N+c]), .i_valid(m_ivalid[r*N+c]),
                .i_shift_u(m_shift[((r+N-1)%N)*N+c]),
                .i_shift_l(m_shift[r*N+(c+N-1)%N]),
                .o_shift(m_shift[r*N+c]), .o_pkt(m_pkt[r*N+c]),
                .o_valid(m_valid[r*N+c]), .o_done(m_done[r*N+c]),
                .o_conflict(m_conf[r*N+c]), .o_conflict_cnt(m_cnt[r*N+c])
            );
        end
    end

    // Monitors
    always @(negedge clk) begin
        if (s_done) begin
            if (sq.size() == 0) begin
                check("s_unexpected_done", 1, 0);
            end else begin
                s_e = sq.pop_front();
                check("s_done_edge", edges, s_e.done_edge);
                check("s_pkt", s_pkt, s_e.pkt);
                check("s_valid", s_valid, s_e.valid);
                check("s_conflict", s_conflict, s_e.conflict);
                check("s_cnt", s_cnt, s_e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (m_done[0]) begin
            for (int j = 0; j < NP; j++) begin
                if (mq.size() == 0) begin
                    check($sformatf("m%0d_unexpected_done", j), 1, 0);
                end else begin
                    m_e = mq.pop_front();
                    check($sformatf("m%0d_done", j), m_done[j], 1);
                    check($sformatf("m%0d_pkt", j), m_pkt[j], m_e.pkt);
                    check($sformatf("m%0d_valid", j), m_valid[j], m_e.valid);
                    check($sformatf("m%0d_conflict", j), m_conf[j], m_e.conflict);
                    check($sformatf("m%0d_cnt", j), m_cnt[j], m_e.cnt);
                end
            end
        end
    end

    // Drivers
    task automatic s_pulse(input logic [PW-1:0] pkt, input logic v);
        @(posedge clk); #2;
        s_start = 1'b1; s_ipkt = pkt; s_ivalid = v;
        @(posedge clk); #2;
        s_start = 1'b0; s_ivalid = 1'b0;
    endtask

    task automatic s_push(input logic [PW-1:0] pkt, input logic v);
        exp_t e;
        e.pkt = pkt; e.valid = v; e.conflict = 1'b0; e.cnt = 8'd0;
        e.done_edge = edges + 2 * N + 1;
        sq.push_back(e);
    endtask

    task automatic s_drain(input string name);
        for (int k = 0; k < 60 && sq.size() != 0; k++) @(negedge clk);
        check(name, sq.size() == 0, 1);
    endtask

    task automatic m_push(input logic [PW-1:0] pkt, input logic v, input logic cf, input logic [7:0] cnt);
        exp_t e;
        e.pkt = pkt; e.valid = v; e.conflict = cf; e.cnt = cnt; e.done_edge = 0;
        mq.push_back(e);
    endtask

    task automatic m_run(input string name);
        @(posedge clk); #2;
        m_start = 1'b1;
        @(posedge clk); #2;
        m_start = 1'b0;
        for (int k = 0; k < 60 && mq.size() != 0; k++) @(negedge clk);
        check(name, mq.size() == 0, 1);
    endtask

    int e0;

    initial begin
        s_rst = 1'b1; s_start = 1'b0; s_ivalid = 1'b0; s_ipkt = '0;
        s_shift_u = '0; s_shift_l = '0;
        m_rst = 1'b1; m_start = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_ipkt[i] = '0; m_ivalid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        s_rst = 1'b0; m_rst = 1'b0;

        check("rst_shift", s_shift, 0);
        check("rst_pkt", s_pkt, 0);
        check("rst_valid", s_valid, 0);
        check("rst_done", s_done, 0);
        check("rst_conflict", s_conflict, 0);
        check("rst_cnt", s_cnt, 0);
        check("rst_mesh_done", m_done[5], 0);

        // Own-index packet on a lone PE: delivered after 2N+1 edges.
        s_pulse({4'd6, 4'h9}, 1'b1);
        check("start_loads_shift", s_shift, 9'h169);
        s_push(8'h69, 1'b1);
        s_drain("single_own_timeout");

        // Packet for another row: nothing delivered; start in DONE clears o_valid.
        s_pulse({4'd3, 4'h5}, 1'b1);
        check("done_start_clears_valid", s_valid, 0);
        s_push(8'h00, 1'b0);
        s_drain("single_other_timeout");

        // Start pulsed mid ROW_SHIFT must be ignored.
        s_pulse({4'd6, 4'h1}, 1'b1);
        s_push(8'h61, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        s_start = 1'b1; s_ipkt = {4'd6, 4'hE}; s_ivalid = 1'b1;
        @(posedge clk); #2;
        s_start = 1'b0; s_ivalid = 1'b0;
        s_drain("ignored_start_timeout");

        // Reset with simultaneous start at COL_SHIFT counter 2.
        s_pulse({4'd6, 4'h2}, 1'b1);
        e0 = edges;
        while (edges < e0 + N + 2) @(posedge clk);
        #2;
        s_rst = 1'b1; s_start = 1'b1; s_ivalid = 1'b1; s_ipkt = {4'd6, 4'h3};
        @(posedge clk); #2;
        s_rst = 1'b0; s_start = 1'b0; s_ivalid = 1'b0;
        check("midrst_shift", s_shift, 0);
        check("midrst_pkt", s_pkt, 0);
        check("midrst_valid", s_valid, 0);
        check("midrst_done", s_done, 0);
        check("midrst_conflict", s_conflict, 0);
        repeat (3 * N) @(posedge clk);
        #2;
        check("midrst_shift_idle", s_shift, 0);

        // Mesh permutation: PE i sends dest 15-i, payload i.
        for (int i = 0; i < NP; i++) begin
            m_ipkt[i]   = {4'(NP - 1 - i), 4'(i)};
            m_ivalid[i] = 1'b1;
            m_push({4'(i), 4'(NP - 1 - i)}, 1'b1, 1'b0, 8'd0);
        end
        m_run("mesh_perm_timeout");

        // Two packets for PE 5: its own arrives first, PE 4's is dropped.
        for (int i = 0; i < NP; i++) begin
            m_ipkt[i] = '0; m_ivalid[i] = 1'b0;
        end
        m_ipkt[5] = {4'd5, 4'hA}; m_ivalid[5] = 1'b1;
        m_ipkt[4] = {4'd5, 4'hB}; m_ivalid[4] = 1'b1;
        for (int j = 0; j < NP; j++) begin
            if (j == 5) m_push({4'd5, 4'hA}, 1'b1, 1'b1, CNT1);
            else        m_push(8'h00, 1'b0, 1'b0, 8'd0);
        end
        m_run("mesh_conflict_timeout");

        // All invalid: done still pulses, nothing delivered, flags cleared.
        for (int i = 0; i < NP; i++) begin
            m_ipkt[i] = '0; m_ivalid[i] = 1'b0;
            m_push(8'h00, 1'b0, 1'b0, 8'd0);
        end
        m_run("mesh_empty_timeout");

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
